// File: rtl/ah_pl2ddr_sample_packer_if.sv
// Sample input stream and packed 32-bit word output stream of the PL-to-DDR sample packer.
// The packer sits on the slave side; the sample source and word sink drive the master side.
interface ah_pl2ddr_sample_packer_if #(
    parameter int DATA_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_en;
    logic [31:0]           out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output data_in,
        output data_en,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  data_in,
        input  data_en,
        input  out_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/ah_pl2ddr_sample_packer.sv
// Packs DATA_WIDTH-bit samples (keeping 1 of N strobes) into 32-bit words, first sample in the LSBs.
// Latency: a word is offered the cycle after its last sample; the partial word is zero-filled and flushed on stop/count.
// Backpressure: out_valid/out_ready; a word completing into a full stage is dropped (overflow). AH_PL2DDR_PACKER_FIFO_EN: 4-deep FIFO stage.

`ifdef AH_PL2DDR_PACKER_FIFO_EN
// Small synchronous FIFO; DEPTH must be a power of two.
// Latency: one cycle from write to read visibility; head word is shown combinationally.
// Backpressure: wr_rdy low when DEPTH entries are held, even if a read happens that cycle.
module ah_pl2ddr_packer_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_rdy
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_wr;
    logic             do_rd;

    assign wr_rdy = (count != (PTR_W+1)'(DEPTH));
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign do_wr  = wr_vld && wr_rdy;
    assign do_rd  = rd_vld && rd_rdy;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(do_wr) - (PTR_W+1)'(do_rd);
        end
    end
endmodule
`endif

module ah_pl2ddr_sample_packer #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                            clk,
    input  logic                            aresetn,
    input  logic                            start,
    input  logic                            stop,
    input  logic [31:0]                     number_samples,
    input  logic [31:0]                     undersample_factor,
    ah_pl2ddr_sample_packer_if.slave        bus,
    output logic [31:0]                     samples_collected,
    output logic [31:0]                     words_emitted,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow
);
    localparam int SPW    = 32 / DATA_WIDTH;
    localparam int FILL_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [FILL_W-1:0] LAST_SLOT = FILL_W'(SPW - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [31:0]         cfg_num;
    logic [31:0]         cfg_factor;
    logic [31:0]         us_cnt;
    logic [FILL_W-1:0]   fill_cnt;
    logic [31:0]         pack_word;

    logic                start_run;
    logic                accept;
    logic                push_vld;
    logic                push_en;
    logic [31:0]         push_dat;
    logic                drop;
    logic [31:0]         word_nxt;
    logic [31:0]         sc_nxt;
    logic                stage_rdy;
    logic                stage_empty;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign busy    = (state == RUN) || (state == FLUSH);
    assign done    = (state == DONE);
    assign push_en = push_vld && stage_rdy;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        accept    = 1'b0;
        push_vld  = 1'b0;
        push_dat  = pack_word;
        drop      = 1'b0;
        word_nxt  = pack_word | (32'(bus.data_in) << (32'(fill_cnt) * DATA_WIDTH));
        sc_nxt    = samples_collected;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                accept = bus.data_en && (us_cnt == '0);
                if (accept) begin
                    sc_nxt = sat_inc(samples_collected);
                    if (fill_cnt == LAST_SLOT) begin
                        push_vld = 1'b1;
                        push_dat = word_nxt;
                        drop     = !stage_rdy;
                    end
                end
                // The count test uses the post-accept value so no sample beyond the limit is taken.
                if (stop || ((cfg_num != '0) && (sc_nxt >= cfg_num))) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (fill_cnt != '0) begin
                    push_vld = stage_rdy;
                end else if (stage_empty) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_num           <= '0;
            cfg_factor        <= '0;
            us_cnt            <= '0;
            fill_cnt          <= '0;
            pack_word         <= '0;
            samples_collected <= '0;
            words_emitted     <= '0;
            overflow          <= 1'b0;
        end else if (start_run) begin
            cfg_num           <= number_samples;
            cfg_factor        <= undersample_factor;
            us_cnt            <= '0;
            fill_cnt          <= '0;
            pack_word         <= '0;
            samples_collected <= '0;
            words_emitted     <= '0;
            overflow          <= 1'b0;
        end else begin
            if ((state == RUN) && bus.data_en) begin
                us_cnt <= ((cfg_factor <= 32'd1) || (us_cnt == cfg_factor - 32'd1)) ? '0 : us_cnt + 32'd1;
            end
            if (accept) begin
                samples_collected <= sc_nxt;
                if (fill_cnt == LAST_SLOT) begin
                    fill_cnt  <= '0;
                    pack_word <= '0;
                end else begin
                    fill_cnt  <= fill_cnt + FILL_W'(1);
                    pack_word <= word_nxt;
                end
            end
            if ((state == FLUSH) && push_vld) begin
                fill_cnt  <= '0;
                pack_word <= '0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                words_emitted <= sat_inc(words_emitted);
            end
        end
    end

`ifdef AH_PL2DDR_PACKER_FIFO_EN
    logic        fifo_rd_vld;
    logic [31:0] fifo_rd_dat;

    ah_pl2ddr_packer_fifo #(
        .WIDTH (32),
        .DEPTH (4)
    ) u_out_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .wr_vld  (push_vld),
        .wr_dat  (push_dat),
        .wr_rdy  (stage_rdy),
        .rd_vld  (fifo_rd_vld),
        .rd_dat  (fifo_rd_dat),
        .rd_rdy  (bus.out_ready)
    );

    assign stage_empty   = !fifo_rd_vld;
    assign bus.out_valid = fifo_rd_vld;
    assign bus.out_data  = fifo_rd_dat;
`else
    logic        out_vld_q;
    logic [31:0] out_dat_q;

    // A word leaving this cycle frees the register for a word arriving this cycle.
    assign stage_rdy     = !out_vld_q || bus.out_ready;
    assign stage_empty   = !out_vld_q;
    assign bus.out_valid = out_vld_q;
    assign bus.out_data  = out_dat_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else if (push_en) begin
            out_vld_q <= 1'b1;
            out_dat_q <= push_dat;
        end else if (bus.out_ready) begin
            out_vld_q <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_ah_pl2ddr_sample_packer.sv
// Bench for ah_pl2ddr_sample_packer: 8-, 1- and 16-bit sample instances, word scoreboard per instance.
// Expectations for the backpressure case follow AH_PL2DDR_PACKER_FIFO_EN.
module tb_ah_pl2ddr_sample_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic aresetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] exp8[$];
    logic [31:0] exp1[$];
    logic [31:0] exp16[$];

    ah_pl2ddr_sample_packer_if #(.DATA_WIDTH(8))  bus8 ();
    ah_pl2ddr_sample_packer_if #(.DATA_WIDTH(1))  bus1 ();
    ah_pl2ddr_sample_packer_if #(.DATA_WIDTH(16)) bus16 ();

    logic st8, sp8, busy8, done8, ovf8;
    logic [31:0] num8, fac8, sc8, we8;
    logic st1, sp1, busy1, done1, ovf1;
    logic [31:0] num1, fac1, sc1, we1;
    logic st16, sp16, busy16, done16, ovf16;
    logic [31:0] num16, fac16, sc16, we16;

    ah_pl2ddr_sample_packer #(.DATA_WIDTH(8)) u8 (
        .clk(clk), .aresetn(aresetn), .start(st8), .stop(sp8),
        .number_samples(num8), .undersample_factor(fac8), .bus(bus8),
        .samples_collected(sc8), .words_emitted(we8), .busy(busy8), .done(done8), .overflow(ovf8));

    ah_pl2ddr_sample_packer #(.DATA_WIDTH(1)) u1 (
        .clk(clk), .aresetn(aresetn), .start(st1), .stop(sp1),
        .number_samples(num1), .undersample_factor(fac1), .bus(bus1),
        .samples_collected(sc1), .words_emitted(we1), .busy(busy1), .done(done1), .overflow(ovf1));

    ah_pl2ddr_sample_packer #(.DATA_WIDTH(16)) u16 (
        .clk(clk), .aresetn(aresetn), .start(st16), .stop(sp16),
        .number_samples(num16), .undersample_factor(fac16), .bus(bus16),
        .samples_collected(sc16), .words_emitted(we16), .busy(busy16), .done(done16), .overflow(ovf16));

    // All stimulus tasks enter and leave 1 time unit after a rising edge.
    task automatic start8(input logic [31:0] n, input logic [31:0] f);
        num8 = n; fac8 = f; st8 = 1'b1;
        @(posedge clk); #1 st8 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] d, input logic with_stop);
        bus8.data_in = d; bus8.data_en = 1'b1; sp8 = with_stop;
        @(posedge clk); #1 bus8.data_en = 1'b0; sp8 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if ((which == 0 && done8) || (which == 1 && done1) || (which == 2 && done16)) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: every transfer pops the next expected word of that instance.
    task automatic watch(input int which, input int nwords, input int budget);
        int seen;
        bit has;
        logic v, r;
        logic [31:0] d, e;
        seen = 0;
        for (int c = 0; c < budget && seen < nwords; c++) begin
            @(negedge clk);
            case (which)
                0:       begin v = bus8.out_valid;  r = bus8.out_ready;  d = bus8.out_data;  end
                1:       begin v = bus1.out_valid;  r = bus1.out_ready;  d = bus1.out_data;  end
                default: begin v = bus16.out_valid; r = bus16.out_ready; d = bus16.out_data; end
            endcase
            if (v && r) begin
                seen++;
                has = 1'b1;
                e   = 32'h0;
                case (which)
                    0:       if (exp8.size()  > 0) e = exp8.pop_front();  else has = 1'b0;
                    1:       if (exp1.size()  > 0) e = exp1.pop_front();  else has = 1'b0;
                    default: if (exp16.size() > 0) e = exp16.pop_front(); else has = 1'b0;
                endcase
                n_checks++;
                if (!has) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_word inst=%0d got=%08h want=none", which, d);
                end else if (d !== e) begin
                    n_fail++;
                    $display("FAIL sb_word inst=%0d got=%08h want=%08h", which, d, e);
                end
            end
        end
        n_checks++;
        if (seen < nwords) begin
            n_fail++;
            $display("FAIL sb_timeout inst=%0d got=%0d words want=%0d", which, seen, nwords);
        end
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        #2;
        n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b want=0", bus8.out_valid); end
        n_checks++; if (bus8.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%08h want=0", bus8.out_data); end
        n_checks++; if (sc8 !== 32'h0) begin n_fail++; $display("FAIL reset_samples got=%0d want=0", sc8); end
        n_checks++; if (we8 !== 32'h0) begin n_fail++; $display("FAIL reset_words got=%0d want=0", we8); end
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b want=0", busy8); end
        n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b want=0", done8); end
        n_checks++; if (ovf8 !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%0b want=0", ovf8); end
        #20 aresetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_words;
        bit ok;
        start8(32'd8, 32'd1);
        exp8.push_back(32'h0403_0201);
        exp8.push_back(32'h0807_0605);
        fork
            for (int i = 1; i <= 8; i++) send8(8'(i), 1'b0);
            watch(0, 2, 100);
        join
        @(posedge clk); #1;
        wait_done(0, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_done got=0 want=1"); end
        n_checks++; if (we8 !== 32'd2) begin n_fail++; $display("FAIL full_words got=%0d want=2", we8); end
        n_checks++; if (sc8 !== 32'd8) begin n_fail++; $display("FAIL full_samples got=%0d want=8", sc8); end
        n_checks++; if (ovf8 !== 1'b0) begin n_fail++; $display("FAIL full_overflow got=%0b want=0", ovf8); end
    endtask

    task automatic test_count_limit;
        bit ok;
        start8(32'd5, 32'd0);
        exp8.push_back(32'h0403_0201);
        exp8.push_back(32'h0000_0005);
        fork
            for (int i = 1; i <= 7; i++) send8(8'(i), 1'b0);
            watch(0, 2, 100);
        join
        @(posedge clk); #1;
        wait_done(0, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL limit_done got=0 want=1"); end
        n_checks++; if (sc8 !== 32'd5) begin n_fail++; $display("FAIL limit_samples got=%0d want=5", sc8); end
        n_checks++; if (we8 !== 32'd2) begin n_fail++; $display("FAIL limit_words got=%0d want=2", we8); end
    endtask

    task automatic test_undersample;
        bit ok;
        logic [31:0] w;
        int k;
        w = 32'h0; k = 0;
        num1 = 32'd0; fac1 = 32'd3; st1 = 1'b1;
        @(posedge clk); #1 st1 = 1'b0;
        fork
            begin
                for (int i = 0; i < 96; i++) begin
                    logic b;
                    b = 1'($urandom_range(0, 1));
                    if (i % 3 == 0) begin
                        w[k] = b;
                        k++;
                        if (k == 32) exp1.push_back(w);
                    end
                    bus1.data_in = b; bus1.data_en = 1'b1;
                    @(posedge clk); #1 bus1.data_en = 1'b0;
                end
                sp1 = 1'b1;
                @(posedge clk); #1 sp1 = 1'b0;
            end
            watch(1, 1, 200);
        join
        @(posedge clk); #1;
        wait_done(1, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL us_done got=0 want=1"); end
        n_checks++; if (sc1 !== 32'd32) begin n_fail++; $display("FAIL us_samples got=%0d want=32", sc1); end
        n_checks++; if (we1 !== 32'd1) begin n_fail++; $display("FAIL us_words got=%0d want=1", we1); end
    endtask

    task automatic test_stop;
        bit ok;
        start8(32'd0, 32'd1);
        exp8.push_back(32'h0403_0201);
        fork
            begin
                send8(8'h01, 1'b0); send8(8'h02, 1'b0); send8(8'h03, 1'b0); send8(8'h04, 1'b1);
            end
            watch(0, 1, 50);
        join
        @(posedge clk); #1;
        wait_done(0, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stop4_done got=0 want=1"); end
        n_checks++; if (sc8 !== 32'd4) begin n_fail++; $display("FAIL stop4_samples got=%0d want=4", sc8); end
        n_checks++; if (we8 !== 32'd1) begin n_fail++; $display("FAIL stop4_words got=%0d want=1", we8); end
        start8(32'd0, 32'd1);
        exp8.push_back(32'h0000_BBAA);
        fork
            begin
                send8(8'hAA, 1'b0); send8(8'hBB, 1'b0);
                sp8 = 1'b1; @(posedge clk); #1 sp8 = 1'b0;
            end
            watch(0, 1, 50);
        join
        @(posedge clk); #1;
        wait_done(0, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stop2_done got=0 want=1"); end
        n_checks++; if (sc8 !== 32'd2) begin n_fail++; $display("FAIL stop2_samples got=%0d want=2", sc8); end
    endtask

    task automatic test_backpressure;
        bit ok;
        int bad, nexp;
        logic expect_ovf;
        logic [15:0] s [6];
        logic [31:0] w0, last_we;
`ifdef AH_PL2DDR_PACKER_FIFO_EN
        nexp = 3; expect_ovf = 1'b0;
`else
        nexp = 1; expect_ovf = 1'b1;
`endif
        for (int i = 0; i < 6; i++) s[i] = 16'hA000 + 16'(i * 17);
        w0 = {s[1], s[0]};
        exp16.push_back(w0);
        if (nexp == 3) begin
            exp16.push_back({s[3], s[2]});
            exp16.push_back({s[5], s[4]});
        end
        bus16.out_ready = 1'b0;
        num16 = 32'd0; fac16 = 32'd1; st16 = 1'b1;
        @(posedge clk); #1 st16 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus16.data_in = s[i]; bus16.data_en = 1'b1;
            @(posedge clk); #1 bus16.data_en = 1'b0;
        end
        n_checks++; if (ovf16 !== expect_ovf) begin n_fail++; $display("FAIL bp_overflow got=%0b want=%0b", ovf16, expect_ovf); end
        n_checks++; if (sc16 !== 32'd6) begin n_fail++; $display("FAIL bp_samples got=%0d want=6", sc16); end
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus16.out_valid !== 1'b1 || bus16.out_data !== w0) bad++;
        end
        @(posedge clk); #1;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_stall_stable got=%0d bad cycles want=0", bad); end
        st16 = 1'b1;
        @(posedge clk); #1 st16 = 1'b0;
        n_checks++; if (sc16 !== 32'd6) begin n_fail++; $display("FAIL bp_start_ignored got=%0d want=6", sc16); end
        sp16 = 1'b1;
        @(posedge clk); #1 sp16 = 1'b0;
        n_checks++; if (busy16 !== 1'b1) begin n_fail++; $display("FAIL bp_flush_busy got=%0b want=1", busy16); end
        bus16.out_ready = 1'b1;
        watch(2, nexp, 50);
        @(posedge clk); #1;
        wait_done(2, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_done got=0 want=1"); end
        n_checks++; if (we16 !== 32'(nexp)) begin n_fail++; $display("FAIL bp_words got=%0d want=%0d", we16, nexp); end
        last_we = 32'(nexp);
        sp16 = 1'b1;
        @(posedge clk); #1 sp16 = 1'b0;
        n_checks++; if (done16 !== 1'b1) begin n_fail++; $display("FAIL bp_stop_in_done got=%0b want=1", done16); end
        n_checks++; if (we16 !== last_we) begin n_fail++; $display("FAIL bp_words_after got=%0d want=%0d", we16, last_we); end
    endtask

    task automatic test_reset_mid_run;
        int seen_vld;
        start8(32'd0, 32'd1);
        send8(8'h11, 1'b0); send8(8'h22, 1'b0); send8(8'h33, 1'b0);
        n_checks++; if (sc8 !== 32'd3) begin n_fail++; $display("FAIL mid_samples_before got=%0d want=3", sc8); end
        #3 aresetn = 1'b0;
        #2;
        n_checks++; if (sc8 !== 32'd0) begin n_fail++; $display("FAIL mid_samples got=%0d want=0", sc8); end
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%0b want=0", busy8); end
        n_checks++; if (bus8.out_data !== 32'h0) begin n_fail++; $display("FAIL mid_out_data got=%08h want=0", bus8.out_data); end
        #2 aresetn = 1'b1;
        seen_vld = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus8.out_valid !== 1'b0) seen_vld++;
        end
        @(posedge clk); #1;
        n_checks++; if (seen_vld != 0) begin n_fail++; $display("FAIL mid_no_emit got=%0d valid cycles want=0", seen_vld); end
        n_checks++; if (we8 !== 32'd0) begin n_fail++; $display("FAIL mid_words got=%0d want=0", we8); end
        n_checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin n_fail++; $display("FAIL mid_idle got=busy%0b/done%0b want=0/0", busy8, done8); end
    endtask

    initial begin
        aresetn = 1'b0;
        st8 = 1'b0; sp8 = 1'b0; num8 = '0; fac8 = '0;
        st1 = 1'b0; sp1 = 1'b0; num1 = '0; fac1 = '0;
        st16 = 1'b0; sp16 = 1'b0; num16 = '0; fac16 = '0;
        bus8.data_in = '0;  bus8.data_en = 1'b0;  bus8.out_ready = 1'b1;
        bus1.data_in = '0;  bus1.data_en = 1'b0;  bus1.out_ready = 1'b1;
        bus16.data_in = '0; bus16.data_en = 1'b0; bus16.out_ready = 1'b0;
        test_reset();
        test_full_words();
        test_count_limit();
        test_undersample();
        test_stop();
        test_backpressure();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
